// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package data_ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Access size codes, taken straight from the load/store func3 field.
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  // Byte enables for a store of the given size at an already-aligned lane.
  // Unsigned sizes and unknown codes yield no enables (stores never use them).
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SIZE_B:  m = 4'b0001 << lane;
      SIZE_H:  m = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// Request/status bundle of the load/store port; the tristate data bus stays a direct port.
// Latency: n/a (wires only).
// Backpressure: none; ram_ready gates whether requests are honoured.
interface data_ram_if #(
  parameter int RAM_WIDTH = 31
);
  logic [RAM_WIDTH-1:0] ram_address;
  logic                 ram_we;
  logic                 ram_re;
  logic [2:0]           ram_size;
  logic                 ram_ready;
  logic                 ram_err;

  modport master (
    output ram_address, ram_we, ram_re, ram_size,
    input  ram_ready, ram_err
  );

  modport slave (
    input  ram_address, ram_we, ram_re, ram_size,
    output ram_ready, ram_err
  );
endinterface

// File: rtl/data_ram_lane_merge.sv
// Splices store data into the addressed lanes of a word and right-aligns load data.
// Latency: purely combinational.
// Backpressure: none.
module data_ram_lane_merge
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] bus_dat,
  input  logic [2:0]            size,
  input  logic [1:0]            lane,
  output logic [DATA_WIDTH-1:0] wr_word,
  output logic [DATA_WIDTH-1:0] rd_word
);

  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] bus_shift;

  // Move store data up to its lane, overlay enabled bytes, and shift the old word down for loads.
  always_comb begin
    be        = byte_mask(size, lane);
    bus_shift = bus_dat << {lane, 3'b000};
    rd_word   = old_word >> {lane, 3'b000};
    wr_word   = old_word;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (be[i]) wr_word[8*i +: 8] = bus_shift[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_ram.sv
// Data-memory responder: clears storage after reset, then serves B/H/W stores and lane-shifted loads.
// Latency: stores commit on the clock edge; loads drive ram_data combinationally; ram_err one edge later.
// Backpressure: none; requests before ram_ready are ignored. DATA_RAM_MISALIGN_TRAP_EN traps misaligned H/W.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_WIDTH   = 31,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_ram_if.slave             bus,
  inout  wire [DATA_WIDTH-1:0]  ram_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      init_idx;
  logic                  ready_q, err_q, err_nxt;

  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            lane, eff_lane;
  logic                  in_range, misalign, size_ok;
  logic [DATA_WIDTH-1:0] old_word, wr_word, rd_word, rd_dat;

  logic                  mem_we, bus_oe;
  logic [IDX_W-1:0]      mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  assign word_idx = bus.ram_address[IDX_W+1:2];
  assign lane     = bus.ram_address[1:0];
  // Anything at or above DEPTH_WORDS*4 has a nonzero bit above the word index.
  assign in_range = (bus.ram_address >> (IDX_W + 2)) == '0;
  assign size_ok  = (bus.ram_size == SIZE_B) || (bus.ram_size == SIZE_H) || (bus.ram_size == SIZE_W);
  assign old_word = mem[word_idx];

`ifdef DATA_RAM_MISALIGN_TRAP_EN
  assign misalign = (((bus.ram_size == SIZE_H) || (bus.ram_size == SIZE_HU)) && lane[0])
                  || ((bus.ram_size == SIZE_W) && (lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Align the lane down to the access size; misaligned accesses are already rejected when trapping.
  always_comb begin
    eff_lane = lane;
    case (bus.ram_size)
      SIZE_W:          eff_lane = 2'b00;
      SIZE_H, SIZE_HU: eff_lane = {lane[1], 1'b0};
      default:         eff_lane = lane;
    endcase
  end

  data_ram_lane_merge #(.DATA_WIDTH(DATA_WIDTH)) u_lane_merge (
    .old_word (old_word),
    .bus_dat  (ram_data),
    .size     (bus.ram_size),
    .lane     (eff_lane),
    .wr_word  (wr_word),
    .rd_word  (rd_word)
  );

  // State, init pointer, ready and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_idx <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_q  <= (state_nxt == READY);
      err_q    <= err_nxt;
      if (state == INIT) init_idx <= init_idx + 1'b1;
    end
  end

  // Next state, storage write port, bus drive and error decision.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_wa    = word_idx;
    mem_wd    = wr_word;
    bus_oe    = 1'b0;
    rd_dat    = rd_word;
    err_nxt   = 1'b0;
    case (state)
      INIT: begin
        mem_we = 1'b1;
        mem_wa = init_idx;
        mem_wd = '0;
        if (&init_idx) state_nxt = READY;
      end
      READY: begin
        if (bus.ram_we) begin
          // Store wins over a simultaneous load; the requester owns the bus.
          if (!in_range || misalign || !size_ok) err_nxt = 1'b1;
          else                                   mem_we  = 1'b1;
        end else if (bus.ram_re) begin
          bus_oe = 1'b1;
          if (!in_range || misalign) begin
            rd_dat  = '0;
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Storage write port; contents need no reset since INIT clears them.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign ram_data      = bus_oe ? rd_dat : 'z;
  assign bus.ram_ready = ready_q;
  assign bus.ram_err   = err_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: init timing, directed vector table, random ops vs. array model.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_ram;
  import data_ram_pkg::*;

`ifdef DATA_RAM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tb_oe;
  logic [31:0] tb_dat;
  wire  [31:0] ram_data;

  data_ram_if #(.RAM_WIDTH(31)) bus ();

  data_ram #(.DATA_WIDTH(32), .RAM_WIDTH(31), .DEPTH_WORDS(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_data (ram_data)
  );

  assign ram_data = tb_oe ? tb_dat : 'z;

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] model [256];

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  sz;
    logic [30:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference behaviour: plain byte-address arithmetic over a word array.
  task automatic model_op(input logic we, input logic re, input logic [2:0] sz, input logic [30:0] a,
                          input logic [31:0] d, output logic [31:0] er, output logic ee);
    int unsigned addr, wi, off, sh;
    bit oor, mis, hsz;
    addr = a; wi = addr / 4; off = addr % 4;
    oor = addr >= 1024;
    hsz = (sz == SIZE_H) || (sz == SIZE_HU);
    mis = TRAP && ((hsz && (off % 2 != 0)) || (sz == SIZE_W && off != 0));
    er = '0; ee = 1'b0;
    if (we) begin
      if (oor || mis || !(sz == SIZE_B || sz == SIZE_H || sz == SIZE_W)) ee = 1'b1;
      else if (sz == SIZE_B) model[wi][8*off +: 8] = d[7:0];
      else if (sz == SIZE_H) model[wi][16*(off/2) +: 16] = d[15:0];
      else model[wi] = d;
    end else if (re) begin
      if (oor || mis) ee = 1'b1;
      else begin
        sh = (sz == SIZE_W) ? 0 : (hsz ? (off / 2) * 2 : off);
        er = model[wi] >> (8 * sh);
      end
    end
  endtask

  task automatic do_op(input logic we, input logic re, input logic [2:0] sz, input logic [30:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic oe, output logic err);
    @(negedge clk);
    bus.ram_we = we; bus.ram_re = re; bus.ram_size = sz; bus.ram_address = a;
    tb_oe = we; tb_dat = d;
    #2;
    rd = ram_data;
    oe = dut.bus_oe;
    @(posedge clk); #1;
    err = bus.ram_err;
    bus.ram_we = 1'b0; bus.ram_re = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic run_init(input string tag);
    bit early, saw_oe, saw_err;
    early = 0; saw_oe = 0; saw_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.ram_re = 1'b1; bus.ram_address = 31'h10; bus.ram_size = SIZE_W;
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk); #1;
      if (bus.ram_ready) early = 1;
      if (dut.bus_oe)    saw_oe = 1;
      if (bus.ram_err)   saw_err = 1;
    end
    check({tag, "_ready_low_255"}, 32'(early), 32'd0);
    check({tag, "_no_drive_init"}, 32'(saw_oe), 32'd0);
    check({tag, "_no_err_init"}, 32'(saw_err), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ready_at_256"}, 32'(bus.ram_ready), 32'd1);
    bus.ram_re = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  initial begin
    logic [31:0] rd, er;
    logic        oe, err, ee;
    logic [2:0]  sizes [5];
    int          op;

    sizes[0] = SIZE_B; sizes[1] = SIZE_H; sizes[2] = SIZE_W; sizes[3] = SIZE_BU; sizes[4] = SIZE_HU;

    vt[0]  = '{1'b1, 1'b0, SIZE_W,  31'h010, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, SIZE_B,  31'h011, 32'h000000A5, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, SIZE_W,  31'h010, 32'h0, 32'hDEADA5EF, 1'b0};
    vt[3]  = '{1'b0, 1'b1, SIZE_BU, 31'h013, 32'h0, 32'h000000DE, 1'b0};
    vt[4]  = '{1'b0, 1'b1, SIZE_B,  31'h011, 32'h0, 32'h00DEADA5, 1'b0};
    vt[5]  = '{1'b0, 1'b1, SIZE_H,  31'h012, 32'h0, 32'h0000DEAD, 1'b0};
    vt[6]  = '{1'b1, 1'b0, SIZE_W,  31'h020, 32'hFFFFFFFF, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, SIZE_H,  31'h022, 32'h00001234, 32'h0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, SIZE_W,  31'h020, 32'h0, 32'h1234FFFF, 1'b0};
    vt[9]  = '{1'b1, 1'b0, SIZE_W,  31'h400, 32'hCAFEF00D, 32'h0, 1'b1};
    vt[10] = '{1'b0, 1'b0, SIZE_W,  31'h000, 32'h0, 32'h0, 1'b0};
    vt[11] = '{1'b0, 1'b1, SIZE_W,  31'h400, 32'h0, 32'h00000000, 1'b1};
    vt[12] = '{1'b0, 1'b1, SIZE_W,  31'h3FC, 32'h0, 32'h00000000, 1'b0};
    vt[13] = '{1'b1, 1'b0, SIZE_BU, 31'h050, 32'h00000099, 32'h0, 1'b1};
    vt[14] = '{1'b0, 1'b1, SIZE_W,  31'h050, 32'h0, 32'h00000000, 1'b0};
    vt[15] = '{1'b1, 1'b0, SIZE_W,  31'h041, 32'h11223344, 32'h0, TRAP};
    vt[16] = '{1'b0, 1'b1, SIZE_W,  31'h040, 32'h0, TRAP ? 32'h0 : 32'h11223344, 1'b0};
    vt[17] = '{1'b0, 1'b1, SIZE_HU, 31'h023, 32'h0, TRAP ? 32'h0 : 32'h00001234, TRAP};
    vt[18] = '{1'b1, 1'b0, SIZE_H,  31'h021, 32'h0000ABCD, 32'h0, TRAP};
    vt[19] = '{1'b0, 1'b1, SIZE_W,  31'h020, 32'h0, TRAP ? 32'h1234FFFF : 32'h1234ABCD, 1'b0};
    vt[20] = '{1'b0, 1'b1, SIZE_W,  31'h000, 32'h0, 32'h00000000, 1'b0};

    rst_n = 1'b0; tb_oe = 1'b0; tb_dat = '0;
    bus.ram_we = 1'b0; bus.ram_re = 1'b0; bus.ram_size = SIZE_W; bus.ram_address = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ram_ready), 32'd0);
    check("rst_err", 32'(bus.ram_err), 32'd0);
    check("rst_bus_released", 32'(dut.bus_oe), 32'd0);

    run_init("init1");

    // Directed vectors.
    for (int i = 0; i < 21; i++) begin
      do_op(vt[i].we, vt[i].re, vt[i].sz, vt[i].a, vt[i].d, rd, oe, err);
      model_op(vt[i].we, vt[i].re, vt[i].sz, vt[i].a, vt[i].d, er, ee);
      if (vt[i].re && !vt[i].we) check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
    end

    // Simultaneous store and load: store wins and the DUT keeps off the bus.
    do_op(1'b1, 1'b0, SIZE_W, 31'h030, 32'hFFFF0000, rd, oe, err);
    model_op(1'b1, 1'b0, SIZE_W, 31'h030, 32'hFFFF0000, er, ee);
    do_op(1'b1, 1'b1, SIZE_W, 31'h030, 32'h00000055, rd, oe, err);
    model_op(1'b1, 1'b1, SIZE_W, 31'h030, 32'h00000055, er, ee);
    check("both_no_drive", 32'(oe), 32'd0);
    check("both_bus_value", rd, 32'h00000055);
    do_op(1'b0, 1'b1, SIZE_W, 31'h030, 32'h0, rd, oe, err);
    check("both_written", rd, 32'h00000055);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        we, re;
      logic [2:0]  sz;
      logic [30:0] a;
      logic [31:0] d;
      op = $urandom_range(0, 3);
      we = (op == 1) || (op == 3);
      re = (op == 2) || (op == 3);
      sz = sizes[$urandom_range(0, 4)];
      a  = 31'($urandom_range(0, 1151));
      d  = $urandom;
      do_op(we, re, sz, a, d, rd, oe, err);
      model_op(we, re, sz, a, d, er, ee);
      if (re && !we) check($sformatf("rand%0d_rd a=%0h sz=%0d", n, a, sz), rd, er);
      check($sformatf("rand%0d_oe", n), 32'(oe), 32'(re && !we));
      check($sformatf("rand%0d_err", n), 32'(err), 32'(ee));
    end

    // Reset mid-INIT restarts clearing from word 0.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_ready_async", 32'(bus.ram_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    run_init("init2");

    do_op(1'b0, 1'b1, SIZE_W, 31'h030, 32'h0, rd, oe, err);
    check("post_reinit_cleared_30", rd, 32'h0);
    do_op(1'b0, 1'b1, SIZE_W, 31'h010, 32'h0, rd, oe, err);
    check("post_reinit_cleared_10", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
